bp_redirect_ctrl: RTL and testbench
===================================

Name: bp_redirect_ctrl

Overview:
Branch-prediction sequencing controller for the 5-stage pipeline. It carries each IF-stage BTB prediction alongside its instruction through ID to EX. At EX it compares the prediction with the resolved outcome, then issues the PC redirect and the IF/ID and ID/EX flushes. It also drives the BTB update strobe, and optionally keeps prediction statistics.

Parameters:
CNT_W, 32, width of statistics counters (only used with BP_STATS_EN)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
pred_valid_if  input  1  BTB hit-and-predict-taken for the instruction in IF
pred_target_if  input  32  BTB predicted target for the instruction in IF
if_id_en  input  1  IF/ID register advances this cycle
id_ex_en  input  1  ID/EX register advances this cycle
ex_fire  input  1  valid, non-stalled instruction completes EX this cycle
ex_pc  input  32  PC of the EX instruction
ex_is_branch  input  1  EX instruction is a conditional branch/jump tracked by the BTB
ex_taken  input  1  resolved direction
ex_target  input  32  resolved taken target
redirect  output  1  fetch PC must be overwritten this cycle
redirect_pc  output  32  corrected fetch PC
flush_if_id  output  1  bubble IF/ID
flush_id_ex  output  1  bubble ID/EX
btb_update  output  1  BTB write strobe (maps to BTB is_branch)
btb_pc  output  32  BTB update index PC (= ex_pc)
btb_taken  output  1  BTB update direction (= ex_taken)
btb_target  output  32  BTB update target (= ex_target)
cnt_branch  output  CNT_W  resolved tracked branches
cnt_mispredict  output  CNT_W  redirects issued

Behaviour:
- Tracking registers: pred_id {v, target} and pred_ex {v, target}. Reset value is all 0.
- Per posedge, pred_id is updated with this priority: redirect -> 0; else if_id_en -> {pred_valid_if, pred_target_if}; else hold.
- Per posedge, pred_ex is updated with this priority: redirect -> 0; else id_ex_en -> pred_id; else hold. Stall holds both registers unchanged.
- The mispredict check is combinational on the current pred_ex and EX inputs, and is evaluated only when ex_fire=1:
  - branch, taken, pred_ex.v=0 -> mispredict, redirect_pc=ex_target
  - branch, taken, pred_ex.v=1, target differs -> mispredict, redirect_pc=ex_target
  - branch, not taken, pred_ex.v=1 -> mispredict, redirect_pc=ex_pc+4 (mod 2^32)
  - non-branch, pred_ex.v=1 (BTB alias) -> mispredict, redirect_pc=ex_pc+4
  - all other cases -> no mispredict
- redirect=flush_if_id=flush_id_ex=mispredict. All three are combinational with zero-cycle latency and are high for exactly the cycles in which the condition holds. When redirect=0, redirect_pc=0.
- btb_update = ex_fire & ex_is_branch, combinational. A non-branch alias does not update the BTB. btb_pc, btb_taken and btb_target are pass-throughs.
- If ex_fire=0, all outputs except the counters are 0, regardless of pred_ex.
- A redirect in the same cycle as if_id_en/id_ex_en: the flush wins, so both tracking registers load 0.
- Reset asserted mid-operation clears the tracking registers and counters immediately (async). Outputs then read 0 because pred_ex=0 and only ex_* inputs matter.

Optional Feature:
BP_STATS_EN: when defined, cnt_branch increments on each btb_update, and cnt_mispredict increments on each redirect cycle (including aliases). Both counters saturate at 2^CNT_W-1 and reset to 0. When not defined, the counter registers are absent and both outputs are tied to 0.

Test Plan:
- Reset, then ex_fire=1, ex_is_branch=1, ex_taken=1, ex_target=0x100, no prior prediction -> redirect=1, redirect_pc=0x100, both flushes=1, btb_update=1 in the same cycle.
- pred_valid_if=1, target 0x200, advanced 2 cycles to EX; branch resolves taken to 0x200 -> redirect=0, btb_update=1. With BP_STATS_EN: cnt_branch=1, cnt_mispredict=0.
- Same prediction; branch resolves not taken, ex_pc=0x40 -> redirect_pc=0x44. Next cycle pred_id=pred_ex=0 even though if_id_en=1.
- Predicted 0x200 but resolves taken to 0x300 -> redirect_pc=0x300. Non-branch at ex_pc=0xFFFFFFFC with pred_ex.v=1 -> redirect_pc=0x0, btb_update=0.
- if_id_en=id_ex_en=0 for 3 cycles with ex_fire=0 -> no outputs, and the prediction is held. On release, the prediction is checked correctly. Assert rst mid-hold -> registers clear asynchronously.
- With CNT_W=2 and BP_STATS_EN: 5 mispredicts -> cnt_mispredict saturates at 3.

Source files
------------

// File: rtl/bp_redirect_ctrl.sv
// Branch-prediction redirect controller: tracks BTB predictions IF->ID->EX,
// checks them at EX, drives redirect/flush/BTB update. Optional stats: BP_STATS_EN.
module bp_redirect_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pred_valid_if,
   input  logic [31:0]      pred_target_if,
   input  logic             if_id_en,
   input  logic             id_ex_en,
   input  logic             ex_fire,
   input  logic [31:0]      ex_pc,
   input  logic             ex_is_branch,
   input  logic             ex_taken,
   input  logic [31:0]      ex_target,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             btb_update,
   output logic [31:0]      btb_pc,
   output logic             btb_taken,
   output logic [31:0]      btb_target,
   output logic [CNT_W-1:0] cnt_branch,
   output logic [CNT_W-1:0] cnt_mispredict
);

   logic        r_pid_v;
   logic [31:0] r_pid_tgt;
   logic        r_pex_v;
   logic [31:0] r_pex_tgt;

   logic        w_mis;
   logic [31:0] w_rpc;
   logic        w_upd;
   logic [31:0] w_seq_pc;

   assign w_seq_pc = ex_pc + 32'd4;

   // Prediction tracking in ID; a flush wipes it, otherwise follows IF/ID.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pid_v   <= 1'b0;
         r_pid_tgt <= '0;
      end else if (w_mis) begin
         r_pid_v   <= 1'b0;
         r_pid_tgt <= '0;
      end else if (if_id_en) begin
         r_pid_v   <= pred_valid_if;
         r_pid_tgt <= pred_target_if;
      end
   end

   // Prediction tracking in EX; a flush wipes it, otherwise follows ID/EX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pex_v   <= 1'b0;
         r_pex_tgt <= '0;
      end else if (w_mis) begin
         r_pex_v   <= 1'b0;
         r_pex_tgt <= '0;
      end else if (id_ex_en) begin
         r_pex_v   <= r_pid_v;
         r_pex_tgt <= r_pid_tgt;
      end
   end

   // Compare the carried prediction against the resolved outcome.
   always_comb begin
      w_mis = 1'b0;
      w_rpc = '0;
      if (ex_fire) begin
         if (ex_is_branch) begin
            if (ex_taken) begin
               if (!r_pex_v || (r_pex_tgt != ex_target)) begin
                  w_mis = 1'b1;
                  w_rpc = ex_target;
               end
            end else if (r_pex_v) begin
               w_mis = 1'b1;
               w_rpc = w_seq_pc;
            end
         end else if (r_pex_v) begin
            // Non-branch hit in the BTB: fall through to the next PC.
            w_mis = 1'b1;
            w_rpc = w_seq_pc;
         end
      end
   end

   assign w_upd       = ex_fire & ex_is_branch;
   assign redirect    = w_mis;
   assign redirect_pc = w_rpc;
   assign flush_if_id = w_mis;
   assign flush_id_ex = w_mis;
   assign btb_update  = w_upd;
   assign btb_pc      = ex_fire ? ex_pc : '0;
   assign btb_taken   = ex_fire & ex_taken;
   assign btb_target  = ex_fire ? ex_target : '0;

`ifdef BP_STATS_EN
   logic [CNT_W-1:0] r_cnt_br;
   logic [CNT_W-1:0] r_cnt_mis;

   // Saturating counters of resolved branches and issued redirects.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt_br  <= '0;
         r_cnt_mis <= '0;
      end else begin
         if (w_upd && !(&r_cnt_br))
            r_cnt_br <= r_cnt_br + CNT_W'(1);
         if (w_mis && !(&r_cnt_mis))
            r_cnt_mis <= r_cnt_mis + CNT_W'(1);
      end
   end

   assign cnt_branch     = r_cnt_br;
   assign cnt_mispredict = r_cnt_mis;
`else
   assign cnt_branch     = '0;
   assign cnt_mispredict = '0;
`endif

endmodule

// File: tb/tb_bp_redirect_ctrl.sv
// Directed bench for bp_redirect_ctrl; counters are checked against
// saturating expectations when BP_STATS_EN is defined, else against 0.
module tb_bp_redirect_ctrl;

   localparam int CNT_W = 2;
`ifdef BP_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic             clk;
   logic             rst;
   logic             pred_valid_if;
   logic [31:0]      pred_target_if;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_fire;
   logic [31:0]      ex_pc;
   logic             ex_is_branch;
   logic             ex_taken;
   logic [31:0]      ex_target;
   logic             redirect;
   logic [31:0]      redirect_pc;
   logic             flush_if_id;
   logic             flush_id_ex;
   logic             btb_update;
   logic [31:0]      btb_pc;
   logic             btb_taken;
   logic [31:0]      btb_target;
   logic [CNT_W-1:0] cnt_branch;
   logic [CNT_W-1:0] cnt_mispredict;

   int n_cmp;
   int n_fail;

   bp_redirect_ctrl #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .pred_valid_if (pred_valid_if),
      .pred_target_if(pred_target_if),
      .if_id_en      (if_id_en),
      .id_ex_en      (id_ex_en),
      .ex_fire       (ex_fire),
      .ex_pc         (ex_pc),
      .ex_is_branch  (ex_is_branch),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .flush_if_id   (flush_if_id),
      .flush_id_ex   (flush_id_ex),
      .btb_update    (btb_update),
      .btb_pc        (btb_pc),
      .btb_taken     (btb_taken),
      .btb_target    (btb_target),
      .cnt_branch    (cnt_branch),
      .cnt_mispredict(cnt_mispredict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic rd,
                          input logic [31:0] rpc, input logic upd);
      #1;
      chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, rd});
      chk({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, rd});
      chk({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, rd});
      chk({tag, ".redirect_pc"}, redirect_pc, rpc);
      chk({tag, ".btb_update"}, {31'd0, btb_update}, {31'd0, upd});
   endtask

   task automatic chk_cnt(input string tag, input int b, input int m);
      chk({tag, ".cnt_branch"}, 32'(cnt_branch), STATS != 0 ? 32'(b) : 32'd0);
      chk({tag, ".cnt_mispredict"}, 32'(cnt_mispredict),
          STATS != 0 ? 32'(m) : 32'd0);
   endtask

   task automatic idle_ex();
      ex_fire      = 1'b0;
      ex_is_branch = 1'b0;
      ex_taken     = 1'b0;
      ex_pc        = '0;
      ex_target    = '0;
   endtask

   task automatic resolve(input logic br, input logic tk,
                          input logic [31:0] pc, input logic [31:0] tgt);
      ex_fire      = 1'b1;
      ex_is_branch = br;
      ex_taken     = tk;
      ex_pc        = pc;
      ex_target    = tgt;
   endtask

   // Two advancing cycles move a prediction from IF into EX.
   task automatic load_pred(input logic [31:0] tgt);
      idle_ex();
      pred_valid_if  = 1'b1;
      pred_target_if = tgt;
      if_id_en       = 1'b1;
      id_ex_en       = 1'b1;
      step();
      pred_valid_if  = 1'b0;
      pred_target_if = '0;
      step();
      if_id_en       = 1'b0;
      id_ex_en       = 1'b0;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst = 1'b1;
      pred_valid_if = 1'b0;
      pred_target_if = '0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
      idle_ex();
      #12;
      rst = 1'b0;
      step();

      chk_out("reset", 1'b0, 32'h0, 1'b0);
      chk_cnt("reset", 0, 0);

      resolve(1'b1, 1'b1, 32'h10, 32'h100);
      chk_out("nopred_taken", 1'b1, 32'h100, 1'b1);
      chk("nopred.btb_pc", btb_pc, 32'h10);
      chk("nopred.btb_taken", {31'd0, btb_taken}, 32'd1);
      chk("nopred.btb_target", btb_target, 32'h100);
      step();
      chk_cnt("after_nopred", 1, 1);

      load_pred(32'h200);
      resolve(1'b1, 1'b1, 32'h40, 32'h200);
      chk_out("correct_pred", 1'b0, 32'h0, 1'b1);
      chk_cnt("before_correct", 1, 1);
      step();
      chk_cnt("after_correct", 2, 1);

      resolve(1'b1, 1'b0, 32'h40, 32'h200);
      pred_valid_if  = 1'b1;
      pred_target_if = 32'h500;
      if_id_en       = 1'b1;
      id_ex_en       = 1'b1;
      chk_out("not_taken", 1'b1, 32'h44, 1'b1);
      chk("not_taken.btb_taken", {31'd0, btb_taken}, 32'd0);
      step();
      pred_valid_if  = 1'b0;
      pred_target_if = '0;
      if_id_en       = 1'b0;
      resolve(1'b0, 1'b0, 32'h80, 32'h0);
      chk_out("flush_pex", 1'b0, 32'h0, 1'b0);
      step();
      id_ex_en = 1'b0;
      chk_out("flush_pid", 1'b0, 32'h0, 1'b0);
      chk_cnt("after_nt", 3, 2);

      load_pred(32'h200);
      resolve(1'b1, 1'b1, 32'h60, 32'h300);
      chk_out("wrong_target", 1'b1, 32'h300, 1'b1);
      step();

      load_pred(32'h123);
      resolve(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
      chk_out("alias_wrap", 1'b1, 32'h0, 1'b0);
      step();
      chk_cnt("after_alias", 3, 3);

      load_pred(32'h600);
      pred_valid_if  = 1'b1;
      pred_target_if = 32'h999;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("stall", 1'b0, 32'h0, 1'b0);
      end
      pred_valid_if  = 1'b0;
      pred_target_if = '0;
      resolve(1'b1, 1'b1, 32'h70, 32'h600);
      chk_out("held_pred", 1'b0, 32'h0, 1'b1);
      step();

      load_pred(32'h700);
      step();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      chk_cnt("async_rst", 0, 0);
      resolve(1'b1, 1'b0, 32'h90, 32'h700);
      chk_out("rst_cleared", 1'b0, 32'h0, 1'b1);
      step();
      chk_cnt("post_rst", 1, 0);

      for (int i = 0; i < 5; i++) begin
         resolve(1'b1, 1'b1, 32'h20, 32'h400 + 32'(i));
         chk_out("sat_loop", 1'b1, 32'h400 + 32'(i), 1'b1);
         step();
         chk_cnt("sat_loop", (i + 2 > 3) ? 3 : i + 2,
                 (i + 1 > 3) ? 3 : i + 1);
      end
      idle_ex();
      chk_out("final_idle", 1'b0, 32'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
